stage_latch: RTL and testbench



---
 rtl/stage_latch_pkg.sv | 25 ++
 rtl/stage_latch_ctl.sv | 30 +++
 rtl/stage_latch.sv | 131 +++++++++++++
 tb/tb_stage_latch.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/stage_latch_pkg.sv
// Shared constants and the register-select encoding for the stage_latch pipeline register.
package stage_latch_pkg;

  localparam logic Stop         = 1'b1;
  localparam logic NoStop       = 1'b0;
  localparam logic RstEnable    = 1'b1;
  localparam logic WriteDisable = 1'b0;

  localparam int RegBus     = 32;
  localparam int RegAddrBus = 5;
  localparam int AluOpBus   = 8;

  localparam logic [RegBus-1:0]     ZeroWord   = '0;
  localparam logic [RegAddrBus-1:0] NOPRegAddr = '0;
  localparam logic [AluOpBus-1:0]   EXE_NOP_OP = 8'h00;

  // One-hot select driving the latch register muxes.
  typedef enum logic [3:0] {
    SEL_PASS   = 4'b0001,
    SEL_HOLD   = 4'b0010,
    SEL_BUBBLE = 4'b0100,
    SEL_RESET  = 4'b1000
  } sel_e;

endpackage

// File: rtl/stage_latch_ctl.sv
// Decodes reset, flush and the two relevant stall bits into the one-hot latch select.
module stage_ctl
  import stage_latch_pkg::*;
(
  input  logic rst,
  input  logic flush,
  input  logic stall_cur,
  input  logic stall_next,
  output sel_e sel,
  output logic bubble_ins
);

  // Flush clears the same state as reset but, unlike reset, is a counted bubble.
  always_comb begin
    sel        = SEL_PASS;
    bubble_ins = 1'b0;
    if (rst == RstEnable) begin
      sel = SEL_RESET;
    end else if (flush) begin
      sel        = SEL_RESET;
      bubble_ins = 1'b1;
    end else if (stall_cur == Stop && stall_next == Stop) begin
      sel = SEL_HOLD;
    end else if (stall_cur == Stop) begin
      sel        = SEL_BUBBLE;
      bubble_ins = 1'b1;
    end
  end

endmodule

// File: rtl/stage_latch.sv
// Inter-stage pipeline register with stall/bubble/flush and multi-cycle state return.
// Optional bubble counter port enabled by defining STAGE_LATCH_BUBBLE_CNT_EN.
module stage_latch
  import stage_latch_pkg::*;
#(
  parameter int DATA_W     = RegBus,
  parameter int REG_ADDR_W = RegAddrBus,
  parameter int ALUOP_W    = AluOpBus,
  parameter int CNT_W      = 2,
  parameter int STALL_W    = 6,
  parameter int STAGE_IDX  = 3,
  parameter logic [ALUOP_W-1:0] NOP_OP = ALUOP_W'(EXE_NOP_OP)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [STALL_W-1:0]    stall,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic [REG_ADDR_W-1:0] in_wd,
  input  logic                  in_wreg,
  input  logic [DATA_W-1:0]     in_wdata,
  input  logic [ALUOP_W-1:0]    in_aluop,
  input  logic [DATA_W-1:0]     in_mem_addr,
  input  logic [DATA_W-1:0]     in_reg2,
  input  logic [2*DATA_W-1:0]   in_hilo_temp,
  input  logic [CNT_W-1:0]      in_cnt,
  output logic                  out_valid,
  output logic [REG_ADDR_W-1:0] out_wd,
  output logic                  out_wreg,
  output logic [DATA_W-1:0]     out_wdata,
  output logic [ALUOP_W-1:0]    out_aluop,
  output logic [DATA_W-1:0]     out_mem_addr,
  output logic [DATA_W-1:0]     out_reg2,
  output logic [2*DATA_W-1:0]   hilo_temp_o,
  output logic [CNT_W-1:0]      cnt_o
`ifdef STAGE_LATCH_BUBBLE_CNT_EN
  ,
  output logic [31:0]           bubble_cnt
`endif
);

  localparam int PAY_W = 2 + REG_ADDR_W + ALUOP_W + 3 * DATA_W;

  localparam logic [PAY_W-1:0] BUBBLE = {1'b0, REG_ADDR_W'(NOPRegAddr), WriteDisable,
                                         DATA_W'(ZeroWord), NOP_OP,
                                         DATA_W'(ZeroWord), DATA_W'(ZeroWord)};

  sel_e                sel;
  logic                bubble_ins;
  logic [PAY_W-1:0]    pay_d, pay_q;
  logic [2*DATA_W-1:0] hilo_d, hilo_q;
  logic [CNT_W-1:0]    cnt_d, cnt_q;
  logic                stall_unused;

  assign stall_unused = ^stall;

  stage_ctl u_ctl (
    .rst        (rst),
    .flush      (flush),
    .stall_cur  (stall[STAGE_IDX]),
    .stall_next (stall[STAGE_IDX+1]),
    .sel        (sel),
    .bubble_ins (bubble_ins)
  );

  always_comb begin
    pay_d  = pay_q;
    hilo_d = hilo_q;
    cnt_d  = cnt_q;
    unique case (sel)
      SEL_RESET: begin
        pay_d  = BUBBLE;
        hilo_d = '0;
        cnt_d  = '0;
      end
      // Upstream is stalled mid-op: hand its partial state back for next cycle.
      SEL_BUBBLE: begin
        pay_d  = BUBBLE;
        hilo_d = in_hilo_temp;
        cnt_d  = in_cnt;
      end
      SEL_PASS: begin
        pay_d  = {in_valid, in_wd, in_wreg, in_wdata, in_aluop, in_mem_addr, in_reg2};
        hilo_d = '0;
        cnt_d  = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pay_q  <= BUBBLE;
      hilo_q <= '0;
      cnt_q  <= '0;
    end else begin
      pay_q  <= pay_d;
      hilo_q <= hilo_d;
      cnt_q  <= cnt_d;
    end
  end

  assign {out_valid, out_wd, out_wreg, out_wdata, out_aluop, out_mem_addr, out_reg2} = pay_q;
  assign hilo_temp_o = hilo_q;
  assign cnt_o       = cnt_q;

`ifdef STAGE_LATCH_BUBBLE_CNT_EN
  logic [31:0] bubble_cnt_d, bubble_cnt_q;

  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (bubble_ins && bubble_cnt_q != 32'hFFFF_FFFF) bubble_cnt_d = bubble_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) bubble_cnt_q <= '0;
    else     bubble_cnt_q <= bubble_cnt_d;
  end

  assign bubble_cnt = bubble_cnt_q;
`else
  logic bubble_unused;
  assign bubble_unused = bubble_ins;
`endif

  // Downstream stopped while this stage's upstream runs would silently drop an instruction.
  always_ff @(posedge clk) begin
    if (!rst && !flush) assert (!(stall[STAGE_IDX+1] && !stall[STAGE_IDX]));
  end

endmodule

// File: tb/tb_stage_latch.sv
// Directed plus randomized bench for stage_latch against a behavioural reference model.
module tb_stage_latch;

  localparam int SI = 3;
  localparam logic [7:0] NOP = 8'h00;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_wreg;
  logic [5:0]  stall;
  logic [4:0]  in_wd;
  logic [31:0] in_wdata, in_mem_addr, in_reg2;
  logic [7:0]  in_aluop;
  logic [63:0] in_hilo_temp;
  logic [1:0]  in_cnt;

  logic        out_valid, out_wreg;
  logic [4:0]  out_wd;
  logic [31:0] out_wdata, out_mem_addr, out_reg2;
  logic [7:0]  out_aluop;
  logic [63:0] hilo_temp_o;
  logic [1:0]  cnt_o;
`ifdef STAGE_LATCH_BUBBLE_CNT_EN
  logic [31:0] bubble_cnt;
`endif

  // Reference model state
  logic        e_valid, e_wreg;
  logic [4:0]  e_wd;
  logic [31:0] e_wdata, e_addr, e_reg2, e_bcnt;
  logic [7:0]  e_aluop;
  logic [63:0] e_hilo;
  logic [1:0]  e_cnt;

  int npass = 0, nfail = 0, ntot = 0;

  stage_latch dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_wd(in_wd), .in_wreg(in_wreg), .in_wdata(in_wdata),
    .in_aluop(in_aluop), .in_mem_addr(in_mem_addr), .in_reg2(in_reg2),
    .in_hilo_temp(in_hilo_temp), .in_cnt(in_cnt),
    .out_valid(out_valid), .out_wd(out_wd), .out_wreg(out_wreg), .out_wdata(out_wdata),
    .out_aluop(out_aluop), .out_mem_addr(out_mem_addr), .out_reg2(out_reg2),
    .hilo_temp_o(hilo_temp_o), .cnt_o(cnt_o)
`ifdef STAGE_LATCH_BUBBLE_CNT_EN
    , .bubble_cnt(bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    ntot++;
    assert (got === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_bubble();
    e_valid = 1'b0; e_wd = '0; e_wreg = 1'b0; e_wdata = '0;
    e_aluop = NOP;  e_addr = '0; e_reg2 = '0;
  endtask

  task automatic model_count();
    if (e_bcnt != 32'hFFFF_FFFF) e_bcnt = e_bcnt + 1;
  endtask

  // Applies the priority rules to the inputs that were present at the last edge.
  task automatic model_step();
    if (rst) begin
      model_bubble(); e_hilo = '0; e_cnt = '0; e_bcnt = '0;
    end else if (flush) begin
      model_bubble(); e_hilo = '0; e_cnt = '0; model_count();
    end else if (stall[SI] && stall[SI+1]) begin
      // hold: nothing changes
    end else if (stall[SI]) begin
      model_bubble(); e_hilo = in_hilo_temp; e_cnt = in_cnt; model_count();
    end else begin
      e_valid = in_valid; e_wd = in_wd; e_wreg = in_wreg; e_wdata = in_wdata;
      e_aluop = in_aluop; e_addr = in_mem_addr; e_reg2 = in_reg2;
      e_hilo = '0; e_cnt = '0;
    end
  endtask

  task automatic check_all(input string ph);
    check({ph, ".valid"}, 64'(out_valid), 64'(e_valid));
    check({ph, ".wd"},    64'(out_wd),    64'(e_wd));
    check({ph, ".wreg"},  64'(out_wreg),  64'(e_wreg));
    check({ph, ".wdata"}, 64'(out_wdata), 64'(e_wdata));
    check({ph, ".aluop"}, 64'(out_aluop), 64'(e_aluop));
    check({ph, ".addr"},  64'(out_mem_addr), 64'(e_addr));
    check({ph, ".reg2"},  64'(out_reg2),  64'(e_reg2));
    check({ph, ".hilo"},  hilo_temp_o,    e_hilo);
    check({ph, ".cnt"},   64'(cnt_o),     64'(e_cnt));
`ifdef STAGE_LATCH_BUBBLE_CNT_EN
    check({ph, ".bcnt"},  64'(bubble_cnt), 64'(e_bcnt));
`endif
  endtask

  task automatic tick(input string ph);
    @(posedge clk);
    #1;
    model_step();
    check_all(ph);
  endtask

  task automatic rand_inputs();
    in_valid = 1'($urandom); in_wd = 5'($urandom); in_wreg = 1'($urandom);
    in_wdata = $urandom; in_aluop = 8'($urandom); in_mem_addr = $urandom;
    in_reg2 = $urandom; in_hilo_temp = {$urandom, $urandom}; in_cnt = 2'($urandom);
  endtask

  function automatic logic [5:0] mk_stall(input logic cur, input logic nxt);
    logic [5:0] s;
    s = 6'($urandom);
    s[SI] = cur;
    s[SI+1] = nxt;
    return s;
  endfunction

  initial begin
    logic [31:0] snap_wdata;
    int r;
    rst = 1'b1; flush = 1'b0; stall = '0;
    rand_inputs();
    in_valid = 1'b1; in_wreg = 1'b1; in_aluop = 8'h5A; in_cnt = 2'd3;

    // Reset with busy inputs
    tick("rst0");
    tick("rst1");
    check("rst.aluop_nop", 64'(out_aluop), 64'(NOP));
    check("rst.cnt_zero", 64'(cnt_o), 64'd0);

    // Pass
    rst = 1'b0; stall = 6'b000000;
    in_valid = 1'b1; in_wd = 5'd3; in_wdata = 32'h1234_5678; in_aluop = 8'h21;
    tick("pass");
    check("pass.wdata_const", 64'(out_wdata), 64'h1234_5678);
    check("pass.valid_const", 64'(out_valid), 64'd1);

    // Hold keeps the loaded payload for 3 cycles despite new inputs
    snap_wdata = out_wdata;
    for (int i = 0; i < 3; i++) begin
      stall = 6'b011111;
      rand_inputs();
      tick("hold");
      check("hold.wdata_snap", 64'(out_wdata), 64'(snap_wdata));
    end

    // Bubble with state capture
    stall = 6'b001111; rand_inputs();
    in_hilo_temp = 64'h0000_0001_0000_0002; in_cnt = 2'd1;
    tick("bubble");
    check("bubble.hilo_const", hilo_temp_o, 64'h0000_0001_0000_0002);
    check("bubble.cnt_const", 64'(cnt_o), 64'd1);
    check("bubble.aluop_const", 64'(out_aluop), 64'(NOP));

    // Hold keeps captured state, then flush overrides hold
    stall = 6'b011111; rand_inputs();
    tick("hold_state");
    flush = 1'b1; rand_inputs();
    tick("flush_hold");
    check("flush.hilo_zero", hilo_temp_o, 64'd0);
    check("flush.cnt_zero", 64'(cnt_o), 64'd0);
    flush = 1'b0;

`ifdef STAGE_LATCH_BUBBLE_CNT_EN
    rst = 1'b1; tick("cnt_rst");
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin stall = 6'b001111; rand_inputs(); tick("cnt_bub"); end
    for (int i = 0; i < 2; i++) begin stall = 6'b011111; rand_inputs(); tick("cnt_hold"); end
    flush = 1'b1; tick("cnt_flush");
    flush = 1'b0;
    check("bcnt.six", 64'(bubble_cnt), 64'd6);
`endif

    // Randomized legal traffic
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 99));
      rst   = (r < 3);
      flush = (r >= 3 && r < 11);
      case ($urandom_range(0, 2))
        0: stall = mk_stall(1'b0, 1'b0);
        1: stall = mk_stall(1'b1, 1'b0);
        default: stall = mk_stall(1'b1, 1'b1);
      endcase
      rand_inputs();
      tick("rand");
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
